unidade_de_busca: RTL and testbench

- Instruction-fetch stage of the single-cycle MIPS core; directly upstream of the instruction memory.
- Holds the program counter and drives the word-aligned fetch address into the instruction memory.
- Accepts the fetched word back from the memory, selects the next PC (sequential, branch, jump, jump-register) and tracks run/halt/fault status.
- Counts executed instructions for the bench.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/somador_pc.sv | 49 ++++
 rtl/unidade_de_busca.sv | 105 ++++++++++
 tb/tb_unidade_de_busca.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the single-cycle MIPS core: fetch
//                status encodings, opcode constants, halt word default and
//                an immediate sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Fetch-stage status as seen on the estado port
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HALT  = 2'b01,
    FAULT = 2'b10
  } estado_t;

  // Primary opcodes (instrucao[31:26]) relevant to control flow
  localparam logic [5:0] c_op_j   = 6'h02;
  localparam logic [5:0] c_op_jal = 6'h03;
  localparam logic [5:0] c_op_beq = 6'h04;
  localparam logic [5:0] c_op_bne = 6'h05;

  // Encoding that stops fetch unless overridden at the top level
  localparam logic [31:0] c_halt_word_padrao = 32'hFFFF_FFFF;

  // Sign-extend a 16-bit immediate to a full data word
  function automatic logic [31:0] estende_sinal(input logic [15:0] valor);
    return {{16{valor[15]}}, valor};
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/somador_pc.sv
`default_nettype none
// ============================================================================
//  Module      : somador_pc
//  Description : Combinational next-PC selection for the fetch stage.
//                Produces pc+4, the branch and jump targets, and picks one
//                with priority jump_reg > jump > branch > sequential.
//  Revision    : 1.0 - initial release
// ============================================================================
module somador_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] campo_instr,   // instrucao[25:0]: jump index / immediate
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] reg_alvo,
  output logic [31:0] pc_mais4,
  output logic [31:0] pc_prox
);

  logic [31:0] w_imm;
  logic [31:0] w_alvo_branch;
  logic [31:0] w_alvo_jump;

  // Sequential successor; wraps modulo 2^32 so the range check catches it
  assign pc_mais4 = pc + 32'd4;

  // Branch offset is a signed word count relative to the delay-free pc+4
  assign w_imm         = estende_sinal(campo_instr[15:0]);
  assign w_alvo_branch = pc_mais4 + {w_imm[29:0], 2'b00};

  // Pseudo-direct jump keeps the upper nibble of pc+4
  assign w_alvo_jump   = {pc_mais4[31:28], campo_instr, 2'b00};

  // Priority select: several controls high at once is legal, highest wins
  always_comb begin
    pc_prox = pc_mais4;
    if (jump_reg) begin
      pc_prox = reg_alvo;
    end else if (jump) begin
      pc_prox = w_alvo_jump;
    end else if (branch) begin
      pc_prox = w_alvo_branch;
    end
  end

endmodule : somador_pc
`default_nettype wire

// File: rtl/unidade_de_busca.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_de_busca
//  Description : Instruction-fetch stage. Holds the program counter, drives
//                the fetch address, forwards the fetched word to decode,
//                tracks RUN/HALT/FAULT status and counts completed
//                instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module unidade_de_busca
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS  = 256,
  parameter logic [31:0] HALT_WORD  = c_halt_word_padrao
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] addr,
  input  logic [31:0] instrucao,
  output logic [31:0] instr_out,
  output logic [31:0] pc_mais4,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] reg_alvo,
  output logic [1:0]  estado,
  output logic [31:0] contador
);

  // One past the last legal byte address; 33 bits so large depths cannot wrap
  localparam logic [32:0] c_limite = 33'(MEM_WORDS) * 33'd4;

  estado_t     r_estado;
  estado_t     w_estado_prox;
  logic [31:0] r_pc;
  logic [31:0] w_pc_prox;
  logic [31:0] r_contador;
  logic [31:0] w_contador_prox;
  logic [31:0] w_pc_alvo;
  logic        w_endereco_invalido;
  logic        w_palavra_halt;

  somador_pc u_somador_pc (
    .pc          (r_pc),
    .campo_instr (instrucao[25:0]),
    .branch      (branch),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .reg_alvo    (reg_alvo),
    .pc_mais4    (pc_mais4),
    .pc_prox     (w_pc_alvo)
  );

  // Misaligned or out-of-range pc; evaluated regardless of stall
  assign w_endereco_invalido = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} >= c_limite);
  assign w_palavra_halt      = (instrucao == HALT_WORD);

  assign addr      = r_pc;
  assign estado    = r_estado;
  assign contador  = r_contador;
  assign instr_out = (r_estado == RUN) ? instrucao : 32'h0000_0000;

  // Next-state, next-pc and next-count; HALT/FAULT hold everything
  always_comb begin
    w_estado_prox   = r_estado;
    w_pc_prox       = r_pc;
    w_contador_prox = r_contador;
    case (r_estado)
      RUN: begin
        if (w_endereco_invalido) begin
          w_estado_prox = FAULT;
        end else if (!stall) begin
          if (w_palavra_halt) begin
            w_estado_prox = HALT;
          end else begin
            w_pc_prox = w_pc_alvo;
            if (r_contador != 32'hFFFF_FFFF) begin
              w_contador_prox = r_contador + 32'd1;
            end
          end
        end
      end
      default: begin
        w_estado_prox = r_estado;
      end
    endcase
  end

  // State, pc and counter registers; reset dominates every other condition
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_estado   <= RUN;
      r_pc       <= RESET_ADDR;
      r_contador <= 32'd0;
    end else begin
      r_estado   <= w_estado_prox;
      r_pc       <= w_pc_prox;
      r_contador <= w_contador_prox;
    end
  end

endmodule : unidade_de_busca
`default_nettype wire

// File: tb/tb_unidade_de_busca.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unidade_de_busca
//  Description : Directed self-checking bench for the fetch stage, with a
//                small zero-latency instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_de_busca;

  logic        clk;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] instrucao;
  logic [31:0] instr_out;
  logic [31:0] pc_mais4;
  logic        stall;
  logic        branch;
  logic        jump;
  logic        jump_reg;
  logic [31:0] reg_alvo;
  logic [1:0]  estado;
  logic [31:0] contador;

  logic [31:0] r_mem [0:255];

  int n_testes;
  int n_falhas;

  unidade_de_busca #(
    .RESET_ADDR (32'h0000_0000),
    .MEM_WORDS  (256),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .instrucao (instrucao),
    .instr_out (instr_out),
    .pc_mais4  (pc_mais4),
    .stall     (stall),
    .branch    (branch),
    .jump      (jump),
    .jump_reg  (jump_reg),
    .reg_alvo  (reg_alvo),
    .estado    (estado),
    .contador  (contador)
  );

  // Zero-latency instruction memory
  assign instrucao = r_mem[addr[9:2]];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: observed %h expected %h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic limpa_mem();
    for (int i = 0; i < 256; i++) r_mem[i] = 32'h0000_0000;
  endtask

  task automatic aplica_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    n_testes = 0;
    n_falhas = 0;
    reset_n  = 1'b0;
    stall    = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    jump_reg = 1'b0;
    reg_alvo = 32'h0;
    limpa_mem();

    // 1. Reset state and four sequential nops
    aplica_reset();
    verifica("reset_addr", addr, 32'h0);
    verifica("reset_estado", {30'h0, estado}, 32'h0);
    verifica("reset_contador", contador, 32'h0);
    verifica("reset_pc_mais4", pc_mais4, 32'h4);
    for (int k = 0; k < 4; k++) begin
      verifica("seq_addr", addr, 32'(4 * k));
      tick();
    end
    verifica("seq_contador", contador, 32'd4);
    verifica("seq_estado", {30'h0, estado}, 32'h0);

    // 2. Backward and forward branches from pc=8
    aplica_reset();
    tick(); tick();
    r_mem[2] = 32'h1000_FFFE;
    branch = 1'b1;
    #1;
    verifica("branch_instr_out", instr_out, 32'h1000_FFFE);
    tick();
    branch = 1'b0;
    verifica("branch_back_addr", addr, 32'h4);
    tick();
    verifica("branch_return_addr", addr, 32'h8);
    r_mem[2] = 32'h1000_0003;
    branch = 1'b1;
    tick();
    branch = 1'b0;
    verifica("branch_fwd_addr", addr, 32'h18);
    verifica("branch_contador", contador, 32'd5);

    // 3. Jump, jump beats branch, jump_reg beats jump
    limpa_mem();
    aplica_reset();
    for (int k = 0; k < 4; k++) tick();
    r_mem[4]  = 32'h0800_0020;
    r_mem[32] = 32'h0800_0010;
    r_mem[16] = 32'h0800_0020;
    jump = 1'b1;
    tick();
    verifica("jump_addr", addr, 32'h80);
    branch = 1'b1;
    tick();
    branch = 1'b0;
    verifica("jump_over_branch", addr, 32'h40);
    jump_reg = 1'b1;
    reg_alvo = 32'h0000_0100;
    tick();
    jump = 1'b0;
    jump_reg = 1'b0;
    verifica("jr_over_jump", addr, 32'h100);

    // 4. Misaligned jr target faults one cycle later
    limpa_mem();
    aplica_reset();
    jump_reg = 1'b1;
    reg_alvo = 32'h0000_0402;
    tick();
    jump_reg = 1'b0;
    verifica("jr_mis_addr", addr, 32'h402);
    verifica("jr_mis_still_run", {30'h0, estado}, 32'h0);
    tick();
    verifica("fault_estado", {30'h0, estado}, 32'h2);
    verifica("fault_addr_held", addr, 32'h402);
    verifica("fault_instr_out", instr_out, 32'h0);
    jump = 1'b1;
    tick();
    jump = 1'b0;
    verifica("fault_ignores_jump", addr, 32'h402);
    verifica("fault_contador", contador, 32'd1);

    // 4b. Aligned jr just past the memory end also faults; last word is legal
    aplica_reset();
    jump_reg = 1'b1;
    reg_alvo = 32'h0000_03FC;
    tick();
    reg_alvo = 32'h0000_0400;
    tick();
    jump_reg = 1'b0;
    verifica("last_word_ok", {30'h0, estado}, 32'h0);
    verifica("range_addr", addr, 32'h400);
    tick();
    verifica("range_fault", {30'h0, estado}, 32'h2);

    // 5. Halt word at pc=0x0C, then reset recovers
    limpa_mem();
    r_mem[3] = 32'hFFFF_FFFF;
    aplica_reset();
    tick(); tick(); tick();
    verifica("pre_halt_addr", addr, 32'hC);
    verifica("pre_halt_instr", instr_out, 32'hFFFF_FFFF);
    tick();
    verifica("halt_estado", {30'h0, estado}, 32'h1);
    verifica("halt_addr", addr, 32'hC);
    verifica("halt_contador", contador, 32'd3);
    verifica("halt_instr_out", instr_out, 32'h0);
    tick();
    verifica("halt_held_addr", addr, 32'hC);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    verifica("rst_after_halt_addr", addr, 32'h0);
    verifica("rst_after_halt_estado", {30'h0, estado}, 32'h0);
    verifica("rst_after_halt_contador", contador, 32'h0);

    // 6. Three stalled cycles at pc=4
    limpa_mem();
    r_mem[1] = 32'h1234_5678;
    aplica_reset();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      verifica("stall_addr", addr, 32'h4);
      verifica("stall_contador", contador, 32'd1);
      verifica("stall_instr_out", instr_out, 32'h1234_5678);
    end
    stall = 1'b0;
    tick();
    verifica("unstall_addr", addr, 32'h8);
    verifica("unstall_contador", contador, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule : tb_unidade_de_busca
`default_nettype wire
